vip_horizontal_projection: RTL
==============================

Name: vip_horizontal_projection

Overview:
Upstream neighbour of the vertical projection stage in the plate-location chain. It consumes the binarised pixel stream and counts set pixels per row inside a column window. It finds the longest contiguous band of "hot" rows in each frame. At the next frame start it publishes that band's top and bottom rows, which drive the vertical projection's vertical_start/vertical_end inputs. The video stream passes through with fixed latency.

Parameters:
IMG_HDISP, 10'd640, active pixels per line
IMG_VDISP, 10'd480, active lines per frame
ROW_THRESH, 10'd20, row is hot when its count is strictly greater than this
MIN_ROWS, 10'd8, minimum band height in rows; shorter bands are discarded

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  frame valid, high during frame
per_frame_href  in  1  line valid
per_frame_clken  in  1  pixel strobe
per_img_Bit  in  1  binarised pixel, 1 = set
horizon_start  in  10  column window lower bound, exclusive
horizon_end  in  10  column window upper bound, exclusive
post_frame_vsync  out  1  per_frame_vsync delayed 2 cycles
post_frame_href  out  1  per_frame_href delayed 2 cycles
post_frame_clken  out  1  per_frame_clken delayed 2 cycles
post_img_Bit  out  1  per_img_Bit delayed 2 cycles (see optional feature)
max_line_up  out  10  top row of the best band of the previous frame
max_line_down  out  10  bottom row of the best band of the previous frame
plate_found  out  1  high when the previous frame produced a band of at least MIN_ROWS rows

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Passthrough: a 2-stage register on vsync/href/clken/Bit. Stage 1 is used for edge detection.
- Edge flags come from stage 1 vs stage 2:
  - vs_rise = frame start
  - href_fall = line end
- Position counters:
  - x_cnt increments on stage-1 clken; clears on href_fall.
  - y_cnt increments on href_fall.
  - Both clear on vs_rise.
- Row accumulator row_cnt (10 bit):
  - Adds stage-1 Bit when stage-1 clken is high and horizon_start < x_cnt < horizon_end.
  - Saturates at 1023.
  - Clears on href_fall, after evaluation.
- Row evaluation on href_fall, for row y_cnt; hot = row_cnt > ROW_THRESH.
- FSM:
  - IDLE, hot: run_start <= y_cnt; go to RUN.
  - IDLE, not hot: stay in IDLE.
  - RUN, hot: stay in RUN.
  - RUN, not hot: close the run with end = y_cnt-1; go to IDLE.
- Closing a run:
  - len = end - run_start + 1.
  - If len >= MIN_ROWS and len > best_len, set best_start/best_end/best_len. Ties keep the earlier band.
- vs_rise (frame boundary):
  - If the FSM is in RUN, first close the run with end = y_cnt-1 (combinational, same cycle).
  - Then latch max_line_up <= best_start, max_line_down <= best_end, plate_found <= (best_len != 0).
  - Then clear best_*, run_start and y_cnt, and force IDLE.
- When no band qualifies: max_line_up = max_line_down = 0, plate_found = 0.
- Results are stable for a full frame and update exactly 1 cycle after vs_rise.
- horizon_start >= horizon_end means nothing is counted; no band is found.
- Lines beyond IMG_VDISP are evaluated normally; y_cnt wraps at 1024, which the timing never reaches.
- Reset asserted mid-frame: the partial frame is lost; outputs return to 0 until the next complete frame.

Optional Feature:
HPROJ_OVERLAY_EN.
- Defined: post_img_Bit is forced to 1 on stage-2 pixels whose row equals max_line_up or max_line_down and plate_found=1. This draws the band edges for on-screen debug.
- Undefined: post_img_Bit is a pure 2-cycle delay of per_img_Bit.
- Timing is identical in both builds.

Decomposition:
- Shared package vip_proj_pkg holds:
  - the 10-bit coordinate type
  - the FSM state enum (IDLE, RUN)
  - the IMG_HDISP/IMG_VDISP defaults
- Natural sub-module: vip_run_tracker, holding the FSM, run_start, the best-band registers and the close/compare logic. Its inputs are row_valid, hot, y, frame_start. The top level keeps the delay line, counters and accumulator.

Test Plan:
- All-zero 640x480 frame, then a second frame -> after the 2nd vs_rise: plate_found=0, max_line_up=0, max_line_down=0.
- Rows 200..259 with 100 set pixels each inside window 100..500 -> max_line_up=200, max_line_down=259, plate_found=1.
- Two bands: rows 50..59 (10 rows) and 300..339 (40 rows) -> 300/339. Equal 20-row bands at 50 and 300 -> 50/69.
- Band rows 470..479, still open at frame end -> closed at vs_rise; outputs 470/479.
- 5-row band (< MIN_ROWS) -> plate_found=0. Set pixels only at columns 0..99 with window 100..500 -> plate_found=0. Row with exactly 20 set pixels -> not hot.
- Reset pulse mid-frame -> all outputs 0 immediately; next full frame yields correct band. Passthrough latency checked at 2 cycles. With HPROJ_OVERLAY_EN, rows 200/259 read all 1s in the following frame.

Source files
------------

// File: rtl/vip_proj_pkg.sv
// Shared types and defaults for the plate-location projection stages.
// Holds the row/column coordinate type, the run-tracker state encoding and frame-size defaults.
package vip_proj_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  localparam coord_t IMG_HDISP_DEF = 10'd640;
  localparam coord_t IMG_VDISP_DEF = 10'd480;
  localparam coord_t ROW_CNT_MAX   = 10'd1023;

endpackage

// File: rtl/vip_run_tracker.sv
// Tracks contiguous runs of hot rows and keeps the longest qualifying band of the frame.
// The band found in one frame is published on the next frame_start and held for a whole frame.
module vip_run_tracker
  import vip_proj_pkg::*;
#(
  parameter coord_t MIN_ROWS = 10'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       row_valid,
  input  logic       hot,
  input  logic [9:0] y,
  input  logic       frame_start,
  output logic [9:0] max_line_up,
  output logic [9:0] max_line_down,
  output logic       plate_found
);

  run_state_t state;
  coord_t     run_start;
  coord_t     best_start;
  coord_t     best_end;
  coord_t     best_len;

  logic   close_run;
  logic   take_run;
  coord_t run_end;
  coord_t run_len;
  coord_t nxt_start;
  coord_t nxt_end;
  coord_t nxt_len;

  // A run closes on the first cold row, or at the frame boundary if still open.
  // Strict '>' on length keeps the earlier band when two bands tie.
  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    close_run = (state == ST_RUN) && (frame_start || (row_valid && !hot));
    run_end   = y - 10'd1;
    run_len   = y - run_start;
    take_run  = close_run && (run_len >= MIN_ROWS) && (run_len > best_len);
    nxt_start = take_run ? run_start : best_start;
    nxt_end   = take_run ? run_end   : best_end;
    nxt_len   = take_run ? run_len   : best_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      run_start     <= '0;
      best_start    <= '0;
      best_end      <= '0;
      best_len      <= '0;
      max_line_up   <= '0;
      max_line_down <= '0;
      plate_found   <= 1'b0;
    end else if (frame_start) begin
      max_line_up   <= nxt_start;
      max_line_down <= nxt_end;
      plate_found   <= (nxt_len != '0);
      best_start    <= '0;
      best_end      <= '0;
      best_len      <= '0;
      run_start     <= '0;
      state         <= ST_IDLE;
    end else if (row_valid) begin
      case (state)
        ST_IDLE: begin
          if (hot) begin
            run_start <= y;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!hot) begin
            best_start <= nxt_start;
            best_end   <= nxt_end;
            best_len   <= nxt_len;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vip_horizontal_projection.sv
// Horizontal projection: counts set pixels per row inside a column window and reports the
// tallest band of hot rows from the previous frame. Optional macro HPROJ_OVERLAY_EN draws the band edges.
module vip_horizontal_projection
  import vip_proj_pkg::*;
#(
  parameter coord_t ROW_THRESH = 10'd20,
  parameter coord_t MIN_ROWS   = 10'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       per_img_Bit,
  input  logic [9:0] horizon_start,
  input  logic [9:0] horizon_end,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit,
  output logic [9:0] max_line_up,
  output logic [9:0] max_line_down,
  output logic       plate_found
);

  logic vs1, hr1, ck1, bit1;
  logic vs2, hr2, ck2, bit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vs1, hr1, ck1, bit1} <= '0;
      {vs2, hr2, ck2, bit2} <= '0;
    end else begin
      // NOTE: non-blocking assignments so stage 2 captures stage 1's previous value.
      {vs1, hr1, ck1, bit1} <= {per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit};
      {vs2, hr2, ck2, bit2} <= {vs1, hr1, ck1, bit1};
    end
  end

  logic   vs_rise;
  logic   href_fall;
  logic   in_window;
  logic   hot;
  coord_t x_cnt;
  coord_t y_cnt;
  coord_t row_cnt;

  assign vs_rise   = vs1 & ~vs2;
  assign href_fall = hr2 & ~hr1;
  assign in_window = (x_cnt > horizon_start) && (x_cnt < horizon_end);
  assign hot       = (row_cnt > ROW_THRESH);

  // x_cnt is the column of the stage-1 pixel; row_cnt is read by the tracker before it clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_cnt <= '0;
    end else if (vs_rise) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_cnt <= '0;
    end else if (href_fall) begin
      x_cnt   <= '0;
      y_cnt   <= y_cnt + 10'd1;
      row_cnt <= '0;
    end else if (ck1) begin
      x_cnt <= x_cnt + 10'd1;
      if (bit1 && in_window && (row_cnt != ROW_CNT_MAX))
        row_cnt <= row_cnt + 10'd1;
    end
  end

  vip_run_tracker #(
    .MIN_ROWS (MIN_ROWS)
  ) u_run_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_valid     (href_fall),
    .hot           (hot),
    .y             (y_cnt),
    .frame_start   (vs_rise),
    .max_line_up   (max_line_up),
    .max_line_down (max_line_down),
    .plate_found   (plate_found)
  );

  assign post_frame_vsync = vs2;
  assign post_frame_href  = hr2;
  assign post_frame_clken = ck2;

`ifdef HPROJ_OVERLAY_EN
  // y_cnt still holds the stage-2 pixel's row: it only advances after the line's last pixel leaves stage 2.
  assign post_img_Bit = bit2 | (plate_found && ck2 && hr2 &&
                                ((y_cnt == max_line_up) || (y_cnt == max_line_down)));
`else
  assign post_img_Bit = bit2;
`endif

endmodule
